mux16_rr_sched: RTL and testbench

- Round-robin scheduler that shares one 16:1 bit-select datapath among 16 requesters.
- Drives the 4-bit select of the 16:1 mux instance and a one-hot grant vector to requesters.
- Holds each grant until the owner releases it.
- Sits between the requester bank and the mux. The mux itself stays external.

---
 rtl/mux_sched_pkg.sv | 14 +
 rtl/rr_pick16.sv | 24 ++
 rtl/mux16_rr_sched.sv | 77 +++++++
 tb/tb_mux16_rr_sched.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_sched_pkg.sv
// Shared constants, state encoding and one-hot helper for the 16-way round-robin scheduler.
package mux_sched_pkg;
  localparam int N_REQ = 16;
  localparam int SEL_W = 4;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  function automatic logic [N_REQ-1:0] onehot16(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/rr_pick16.sv
// Combinational round-robin pick: first set bit of cand searching from ptr+1 upward, modulo 16.
module rr_pick16
  import mux_sched_pkg::*;
(
  input  logic [N_REQ-1:0] cand,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             found
);
  always_comb begin
    logic [SEL_W-1:0] j;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    // Walk farthest-first so the nearest hit after ptr overwrites; offset 16 wraps to ptr itself.
    for (int k = N_REQ; k >= 1; k--) begin
      j = ptr + SEL_W'(k);
      if (cand[j]) begin
        idx   = j;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux16_rr_sched.sv
// Round-robin owner scheduler for a shared 16:1 mux; grants are held until released.
// Optional forced hand-off after MAX_HOLD cycles when RR_MUX_TIMEOUT_EN is defined.
module mux16_rr_sched
  import mux_sched_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic [7:0]       hold_cnt,
  output logic             timeout
);
`ifdef RR_MUX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [N_REQ-1:0] cand;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_found;
  logic             own_req;
  logic             expire;

  // While granted, ptr is the owner; exclude it so a release or timeout hands off fairly.
  assign cand    = (state == GRANT) ? (req & ~onehot16(ptr)) : req;
  assign own_req = req[ptr];
  assign expire  = TO_EN && (state == GRANT) && own_req && (hold_cnt == HOLD_LAST);
  assign busy    = (state == GRANT);

  rr_pick16 u_pick (
    .cand  (cand),
    .ptr   (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '1;
      gnt      <= '0;
      sel      <= '0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (state == IDLE || !own_req || expire) begin
        if (pick_found) begin
          state    <= GRANT;
          ptr      <= pick_idx;
          gnt      <= onehot16(pick_idx);
          sel      <= pick_idx;
          hold_cnt <= '0;
          timeout  <= expire;
        end else if (expire) begin
          hold_cnt <= '0;
          timeout  <= 1'b1;
        end else begin
          state    <= IDLE;
          gnt      <= '0;
          sel      <= '0;
          hold_cnt <= '0;
        end
      end else if (hold_cnt != 8'hFF) begin
        hold_cnt <= hold_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_mux16_rr_sched.sv
// Scoreboard bench for mux16_rr_sched: directed plan scenarios plus randomized traffic vs a reference model.
module tb_mux16_rr_sched;
  localparam int MAX_HOLD = 8;
`ifdef RR_MUX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        busy;
    logic [7:0]  hold;
    logic        to;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] req = '0;
  logic [15:0] gnt;
  logic [3:0]  sel;
  logic        busy;
  logic [7:0]  hold_cnt;
  logic        timeout;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  exp_t q[$];

  // reference model state
  int m_busy, m_owner, m_ptr, m_hold;

  mux16_rr_sched #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .gnt      (gnt),
    .sel      (sel),
    .busy     (busy),
    .hold_cnt (hold_cnt),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [15:0] c, input int p);
    for (int d = 1; d <= 16; d++) begin
      if (c[(p + d) % 16]) return (p + d) % 16;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 15; m_hold = 0;
  endtask

  task automatic model_step(input logic [15:0] r, output exp_t e);
    bit fire;
    int w;
    logic [15:0] c;
    fire = 1'b0;
    if (m_busy == 0) begin
      if (r != 0) begin
        w = pick(r, m_ptr);
        m_busy = 1; m_owner = w; m_ptr = w; m_hold = 0;
      end
    end else if (r[m_owner] && !(TO_EN && m_hold == MAX_HOLD - 1)) begin
      m_hold = (m_hold >= 255) ? 255 : m_hold + 1;
    end else begin
      fire = r[m_owner];
      c = r;
      c[m_owner] = 1'b0;
      w = pick(c, m_ptr);
      if (w >= 0) begin
        m_owner = w; m_ptr = w; m_hold = 0;
      end else if (fire) begin
        m_hold = 0;
      end else begin
        m_busy = 0; m_hold = 0;
      end
    end
    e.gnt  = m_busy ? (16'h1 << m_owner) : 16'h0;
    e.sel  = m_busy ? 4'(m_owner) : 4'h0;
    e.busy = (m_busy != 0);
    e.hold = m_busy ? 8'(m_hold) : 8'h0;
    e.to   = fire;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one request vector, queue the expected post-edge outputs, land on the next falling edge.
  task automatic step(input logic [15:0] r);
    exp_t e;
    req = r;
    model_step(r, e);
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_gnt", gnt, 16'h0);
    chk("rst_sel", 16'(sel), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_hold", 16'(hold_cnt), 16'h0);
    chk("rst_timeout", 16'(timeout), 16'h0);
    @(negedge clk);
    @(negedge clk);
    q.delete();
    model_reset();
    req = '0;
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  // Monitor: compare every registered output update against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL scoreboard_underflow at %0t", $time);
        end else begin
          e = q.pop_front();
          if (gnt !== e.gnt || sel !== e.sel || busy !== e.busy ||
              hold_cnt !== e.hold || timeout !== e.to) begin
            failures++;
            $display("FAIL sb_cmp got gnt=%h sel=%0d busy=%b hold=%0d to=%b want gnt=%h sel=%0d busy=%b hold=%0d to=%b at %0t",
                     gnt, sel, busy, hold_cnt, timeout, e.gnt, e.sel, e.busy, e.hold, e.to, $time);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r;
    model_reset();
    @(negedge clk);
    do_reset();

    // single request, 1-cycle latency, hold count
    step(16'h0001);
    chk("single_gnt", gnt, 16'h0001);
    chk("single_sel", 16'(sel), 16'h0);
    chk("single_busy", 16'(busy), 16'h1);
    repeat (3) step(16'h0001);
    chk("single_hold3", 16'(hold_cnt), 16'h3);

    // priority from reset, release hand-off with no bubble
    do_reset();
    step(16'h8001);
    chk("prio_gnt", gnt, 16'h0001);
    repeat (3) step(16'h8001);
    step(16'h8000);
    chk("handoff_gnt", gnt, 16'h8000);
    chk("handoff_sel", 16'(sel), 16'hF);
    chk("handoff_busy", 16'(busy), 16'h1);

    // wrap-around from owner 15, then release to idle
    step(16'h0004);
    chk("wrap_gnt", gnt, 16'h0004);
    chk("wrap_sel", 16'(sel), 16'h2);
    step(16'h0000);
    chk("idle_gnt", gnt, 16'h0);
    chk("idle_busy", 16'(busy), 16'h0);
    chk("idle_sel", 16'(sel), 16'h0);

    if (TO_EN) begin
      do_reset();
      step(16'h0021);
      chk("to_first_gnt", gnt, 16'h0001);
      for (int i = 0; i < MAX_HOLD - 1; i++) begin
        step(16'h0021);
        chk("to_hold_gnt", gnt, 16'h0001);
      end
      step(16'h0021);
      chk("to_move_gnt", gnt, 16'h0020);
      chk("to_move_sel", 16'(sel), 16'h5);
      chk("to_move_pulse", 16'(timeout), 16'h1);
      step(16'h0021);
      chk("to_pulse_end", 16'(timeout), 16'h0);

      do_reset();
      step(16'h0010);
      for (int s = 1; s < 20; s++) begin
        step(16'h0010);
        chk("sole_gnt", gnt, 16'h0010);
        chk("sole_hold", 16'(hold_cnt), 16'(s % MAX_HOLD));
        chk("sole_pulse", 16'(timeout), 16'((s % MAX_HOLD) == 0));
      end
    end else begin
      do_reset();
      step(16'h0021);
      repeat (269) step(16'h0021);
      chk("sat_gnt", gnt, 16'h0001);
      chk("sat_hold", 16'(hold_cnt), 16'hFF);
      chk("sat_no_to", 16'(timeout), 16'h0);
    end

    // asynchronous reset while a grant is active, then ptr restarts at 15
    do_reset();
    step(16'h0040);
    step(16'h0040);
    chk("pre_rst_busy", 16'(busy), 16'h1);
    do_reset();
    step(16'h0006);
    chk("post_rst_gnt", gnt, 16'h0002);
    chk("post_rst_sel", 16'(sel), 16'h1);

    // randomized traffic against the reference model
    r = '0;
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 9))
        0: r = 16'($urandom);
        1: r = 16'($urandom) & 16'($urandom) & 16'($urandom);
        2: r = '0;
        3, 4: r[$urandom_range(0, 15)] = ~r[$urandom_range(0, 15)];
        5: r = r & ~gnt;
        default: ;
      endcase
      if (n == 200 || n == 420) do_reset();
      step(r);
    end

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
